sync_fifo_thr: RTL and testbench
================================

Name: sync_fifo_thr

Overview:
Single-clock, parametrised FIFO for same-domain buffering between producer and consumer blocks.
- Generalises the existing FIFO family in data width, depth and watermark thresholds.
- Adds a fill-level count, almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous software reset.
- Optional first-word-fall-through read mode.

Parameters:
DW, 8, data width in bits
DEPTH, 16, number of entries; power of two, >= 4
AF_THR, DEPTH-2, o_almost_full asserts when count >= AF_THR
AE_THR, 2, o_almost_empty asserts when count <= AE_THR

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
sw_rst  input  1  synchronous soft reset, active-high
i_wr_data  input  DW  write data
i_wr_valid  input  1  write request
o_wr_fifo_full  output  1  FIFO full
i_rd_en  input  1  read request (pop)
o_rd_data  output  DW  read data
o_rd_valid  output  1  o_rd_data is valid
o_rd_fifo_empty  output  1  FIFO empty
o_count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH
o_almost_full  output  1  count >= AF_THR
o_almost_empty  output  1  count <= AE_THR
o_overflow  output  1  sticky: write attempted while full
o_underflow  output  1  sticky: read attempted while empty
i_err_clr  input  1  clears o_overflow/o_underflow

Behaviour:
- Reset (rst high, asynchronous):
  - pointers and count = 0, o_rd_valid = 0, o_rd_data = 0
  - o_rd_fifo_empty = 1, o_wr_fifo_full = 0
  - o_almost_empty = 1, o_almost_full = 0
  - o_overflow = 0, o_underflow = 0
- sw_rst (synchronous): same cleared state on the next edge; memory contents are not cleared; sw_rst overrides all other inputs in that cycle.
- Pointers:
  - width $clog2(DEPTH)+1; MSB is the wrap bit.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Wrap from DEPTH-1 to 0 is natural modulo arithmetic.
- Write: accepted iff i_wr_valid && !o_wr_fifo_full, evaluated at the start of the cycle. A write while full is dropped, memory and pointers are unchanged, and o_overflow is set.
- Read (standard mode):
  - Accepted iff i_rd_en && !o_rd_fifo_empty.
  - o_rd_data is registered and o_rd_valid pulses high for exactly 1 cycle after the accepting edge (read latency 1).
  - A read while empty is ignored, o_rd_valid stays 0, and o_underflow is set.
  - o_rd_data holds its last value when no read occurs.
- Simultaneous read+write:
  - Both are judged against start-of-cycle flags.
  - When full: the read is accepted and the write is rejected (overflow set).
  - When empty: the write is accepted and the read is rejected (underflow set).
  - Otherwise both are accepted and count is unchanged.
- Count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH and never goes below 0.
- Flags: o_wr_fifo_full, o_rd_fifo_empty, o_almost_full and o_almost_empty are decoded from registered pointers/count. They reflect the new state on the cycle after the causing edge.
- Sticky errors: o_overflow and o_underflow hold until i_err_clr or a reset. If i_err_clr coincides with a new error event, the flag is set (the set wins).
- Parameter check: elaboration error if DEPTH is not a power of two or AE_THR >= AF_THR.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - The head entry is prefetched into the output register.
  - o_rd_valid is a level meaning "o_rd_data holds the head"; o_rd_fifo_empty = !o_rd_valid.
  - i_rd_en pops the head; the next entry, if any, appears on the following cycle without a bubble.
  - A write accepted at edge k into an empty FIFO gives o_rd_valid = 1 after edge k+1.
  - o_count includes the entry held in the output register.
  - i_rd_en with o_rd_valid = 0 sets o_underflow.
- Undefined: standard mode as in Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - clog2 constant function
  - default DW/DEPTH constants
  - pointer/count width derivation macros
- Sub-module sync_fifo_mem: simple dual-port RAM, DEPTH x DW, one write port and one registered read port, no reset on the array.
- Control logic (pointers, count, flags, FWFT prefetch) stays in sync_fifo_thr.

Test Plan:
All scenarios use DW=8, DEPTH=16, AF_THR=14, AE_THR=2.
1. Reset: rst high 100 ns, then release -> o_rd_fifo_empty=1, o_count=0, o_almost_empty=1, all other flags 0.
2. Fill: write 1..16 with no reads -> o_count=16 and o_wr_fifo_full=1 after the 16th write; o_almost_full rises after the 14th write. A 17th write of 0xAA is dropped and o_overflow=1. Drain then yields 1..16 in order with no 0xAA.
3. Wrap: loop 40 cycles of write-then-read with the count held at 3 -> data monotonic 1..40, pointers wrap twice, no error flags.
4. Simultaneous ops:
   - when full, write 0x55 + read -> read returns 1, o_overflow=1, o_count=15;
   - when empty, write 0x77 + read -> o_underflow=1, o_count=1, next read returns 0x77.
5. sw_rst mid-operation: with count=9, pulse sw_rst -> next cycle o_count=0 and empty=1; a subsequent write of 0x33 then read returns 0x33. i_err_clr clears the sticky flags.
6. FWFT build: write 0x10 into an empty FIFO -> o_rd_valid=1 and o_rd_data=0x10 one cycle later without i_rd_en. Back-to-back pops of 0x10, 0x11, 0x12 complete in 3 consecutive cycles.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the sync_fifo family.
//   clog2()            - constant ceiling-log2 used for address/pointer sizing
//   SYNC_FIFO_DW/DEPTH - default data width and depth
//   `SYNC_FIFO_AW(d)    - RAM address width for depth d
//   `SYNC_FIFO_CNT_W(d) - pointer/count width for depth d (address + wrap bit)
`ifndef SYNC_FIFO_PKG_MACROS
`define SYNC_FIFO_PKG_MACROS
`define SYNC_FIFO_AW(depth) (sync_fifo_pkg::clog2(depth))
`define SYNC_FIFO_CNT_W(depth) (sync_fifo_pkg::clog2(depth) + 1)
`endif

package sync_fifo_pkg;

    localparam int unsigned SYNC_FIFO_DW    = 8;
    localparam int unsigned SYNC_FIFO_DEPTH = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port RAM, DEPTH x DW, for the sync_fifo family.
//   clk      - clock
//   rst      - asynchronous active-high reset (read register only)
//   clr      - synchronous clear of the read register (array untouched)
//   wr_en    - write strobe; wr_addr/wr_data give location and value
//   rd_en    - read strobe; rd_data is registered (latency 1), holds otherwise
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DW    = SYNC_FIFO_DW,
    parameter int unsigned DEPTH = SYNC_FIFO_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with fill count, watermark flags and
// sticky error flags.
//   clk, rst (async, active-high), sw_rst (sync soft reset, overrides all)
//   i_wr_data/i_wr_valid, o_wr_fifo_full         - write side
//   i_rd_en, o_rd_data/o_rd_valid, o_rd_fifo_empty - read side
//   o_count (0..DEPTH), o_almost_full (count >= AF_THR),
//   o_almost_empty (count <= AE_THR)
//   o_overflow/o_underflow sticky, cleared by i_err_clr (a new event wins)
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise reads have one cycle of latency and o_rd_valid is a pulse.
module sync_fifo_thr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DW     = SYNC_FIFO_DW,
    parameter int unsigned DEPTH  = SYNC_FIFO_DEPTH,
    parameter int unsigned AF_THR = DEPTH - 2,
    parameter int unsigned AE_THR = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sw_rst,
    input  logic [DW-1:0]                      i_wr_data,
    input  logic                               i_wr_valid,
    output logic                               o_wr_fifo_full,
    input  logic                               i_rd_en,
    output logic [DW-1:0]                      o_rd_data,
    output logic                               o_rd_valid,
    output logic                               o_rd_fifo_empty,
    output logic [`SYNC_FIFO_CNT_W(DEPTH)-1:0] o_count,
    output logic                               o_almost_full,
    output logic                               o_almost_empty,
    output logic                               o_overflow,
    output logic                               o_underflow,
    input  logic                               i_err_clr
);

    localparam int unsigned AW = `SYNC_FIFO_AW(DEPTH);
    localparam int unsigned PW = `SYNC_FIFO_CNT_W(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_LVL  = PW'(AF_THR);
    localparam logic [PW-1:0] AE_LVL  = PW'(AE_THR);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_thr: DEPTH must be a power of two and >= 4");
    end
    if (AE_THR >= AF_THR) begin : g_bad_thr
        $error("sync_fifo_thr: AE_THR must be below AF_THR");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;
    logic          rd_valid;
    logic          rd_valid_nxt;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef SYNC_FIFO_FWFT_EN
    // rd_ptr addresses the head, which stays in RAM while a copy sits in the
    // output register, so the pointer difference still equals the fill level.
    // Prefetch only entries written before this cycle: no RAM read/write
    // collision, at the cost of one cycle from write to visibility.
    logic [PW-1:0] rd_ptr_nxt;

    assign empty        = !rd_valid;
    assign rd_acc       = i_rd_en && rd_valid;
    assign rd_ptr_nxt   = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    assign mem_rd_en    = (!rd_valid || rd_acc) && (rd_ptr_nxt != wr_ptr);
    assign mem_rd_addr  = rd_ptr_nxt[AW-1:0];
    assign rd_valid_nxt = mem_rd_en || (rd_valid && !rd_acc);
`else
    assign empty        = (wr_ptr == rd_ptr);
    assign rd_acc       = i_rd_en && !empty;
    assign mem_rd_en    = rd_acc;
    assign mem_rd_addr  = rd_ptr[AW-1:0];
    assign rd_valid_nxt = rd_acc;
`endif

    assign wr_acc = i_wr_valid && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_valid    <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (sw_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_valid    <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
            rd_valid    <= rd_valid_nxt;
            o_overflow  <= (i_wr_valid && full) || (o_overflow && !i_err_clr);
            o_underflow <= (i_rd_en && empty) || (o_underflow && !i_err_clr);
        end
    end

    sync_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clr     (sw_rst),
        .wr_en   (wr_acc && !sw_rst),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_wr_data),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (o_rd_data)
    );

    assign o_wr_fifo_full  = full;
    assign o_rd_fifo_empty = empty;
    assign o_rd_valid      = rd_valid;
    assign o_count         = count;
    assign o_almost_full   = (count >= AF_LVL);
    assign o_almost_empty  = (count <= AE_LVL);

endmodule

// File: tb/tb_sync_fifo_thr.sv
// tb_sync_fifo_thr: directed self-checking bench for sync_fifo_thr
// (DW=8, DEPTH=16, AF_THR=14, AE_THR=2).
module tb_sync_fifo_thr;

    logic       clk;
    logic       rst;
    logic       sw_rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int unsigned n_vec;
    int unsigned n_err;

    sync_fifo_thr #(
        .DW     (8),
        .DEPTH  (16),
        .AF_THR (14),
        .AE_THR (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_rst          (sw_rst),
        .i_wr_data       (wr_data),
        .i_wr_valid      (wr_valid),
        .o_wr_fifo_full  (wr_full),
        .i_rd_en         (rd_en),
        .o_rd_data       (rd_data),
        .o_rd_valid      (rd_valid),
        .o_rd_fifo_empty (rd_empty),
        .o_count         (count),
        .o_almost_full   (almost_full),
        .o_almost_empty  (almost_empty),
        .o_overflow      (overflow),
        .o_underflow     (underflow),
        .i_err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] value);
        wr_data  = value;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        sw_rst   = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        err_clr  = 1'b0;

        // 1. reset
        #100;
        rst = 1'b0;
        tick();
        check("rst_empty", rd_empty, 1);
        check("rst_count", count, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_full", wr_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);

`ifdef SYNC_FIFO_FWFT_EN
        // 6. first-word-fall-through
        push(8'h10);
        check("fwft_not_yet", rd_valid, 0);
        push(8'h11);
        check("fwft_valid", rd_valid, 1);
        check("fwft_head", rd_data, 8'h10);
        check("fwft_empty", rd_empty, 0);
        push(8'h12);
        check("fwft_count3", count, 3);
        check("fwft_hold", rd_data, 8'h10);
        rd_en = 1'b1;
        tick();
        check("fwft_pop1_data", rd_data, 8'h11);
        check("fwft_pop1_valid", rd_valid, 1);
        tick();
        check("fwft_pop2_data", rd_data, 8'h12);
        check("fwft_pop2_valid", rd_valid, 1);
        tick();
        check("fwft_pop3_valid", rd_valid, 0);
        check("fwft_pop3_empty", rd_empty, 1);
        check("fwft_pop3_count", count, 0);
        check("fwft_pop3_unf", underflow, 0);
        tick();
        check("fwft_unf", underflow, 1);
        rd_en = 1'b0;
`else
        // 2. fill, overflow, drain
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            check("fill_count", count, 32'(i));
            check("fill_af", almost_full, (i >= 14) ? 1 : 0);
            check("fill_full", wr_full, (i == 16) ? 1 : 0);
        end
        push(8'hAA);
        check("fill_ovf", overflow, 1);
        check("fill_ovf_count", count, 16);
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, 32'(i));
            check("drain_count", count, 32'(16 - i));
            check("drain_ae", almost_empty, (16 - i <= 2) ? 1 : 0);
        end
        rd_en = 1'b0;
        tick();
        check("drain_valid_end", rd_valid, 0);
        check("drain_empty", rd_empty, 1);
        check("drain_hold", rd_data, 16);
        check("drain_unf", underflow, 0);
        pulse_err_clr();
        check("fill_ovf_clr", overflow, 0);

        // 3. wrap with count held at 3
        for (int i = 1; i <= 3; i++) push(8'(i));
        for (int i = 1; i <= 40; i++) begin
            wr_data  = 8'(i + 3);
            wr_valid = 1'b1;
            rd_en    = 1'b1;
            tick();
            check("wrap_data", rd_data, 32'(i));
            check("wrap_count", count, 3);
        end
        wr_valid = 1'b0;
        for (int i = 41; i <= 43; i++) begin
            tick();
            check("wrap_tail", rd_data, 32'(i));
        end
        rd_en = 1'b0;
        tick();
        check("wrap_empty", rd_empty, 1);
        check("wrap_ovf", overflow, 0);
        check("wrap_unf", underflow, 0);

        // 4a. simultaneous write+read when full
        for (int i = 1; i <= 16; i++) push(8'(i));
        check("sim_full", wr_full, 1);
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("simf_data", rd_data, 1);
        check("simf_valid", rd_valid, 1);
        check("simf_ovf", overflow, 1);
        check("simf_count", count, 15);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("simf_drain", rd_data, 32'(i));
        end
        rd_en = 1'b0;
        tick();
        check("simf_empty", rd_empty, 1);
        pulse_err_clr();

        // 4b. simultaneous write+read when empty
        wr_data  = 8'h77;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("sime_unf", underflow, 1);
        check("sime_count", count, 1);
        check("sime_valid", rd_valid, 0);
        tick();
        rd_en = 1'b0;
        check("sime_data", rd_data, 8'h77);
        check("sime_valid2", rd_valid, 1);
        check("sime_count2", count, 0);
        pulse_err_clr();
        check("sime_unf_clr", underflow, 0);

        // 5. soft reset mid-operation
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
        check("swr_count9", count, 9);
        sw_rst   = 1'b1;
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        sw_rst   = 1'b0;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        check("swr_count", count, 0);
        check("swr_empty", rd_empty, 1);
        check("swr_valid", rd_valid, 0);
        check("swr_data", rd_data, 0);
        check("swr_ae", almost_empty, 1);
        push(8'h33);
        rd_en = 1'b1;
        tick();
        check("swr_rd33", rd_data, 8'h33);
        tick();
        rd_en = 1'b0;
        check("swr_unf", underflow, 1);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check("swr_unf_cleared", underflow, 0);
        rd_en   = 1'b1;
        err_clr = 1'b1;
        tick();
        rd_en = 1'b0;
        check("clr_set_wins", underflow, 1);
        tick();
        err_clr = 1'b0;
        check("clr_unf", underflow, 0);
        check("clr_ovf", overflow, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
